mcu_spi_master: RTL and testbench
=================================

# mcu_spi_master

FPGA-side SPI master that drives the MCU control interface of the MiSTeryNano core (`mcu_sclk`, `mcu_csn`, `mcu_mosi`, `mcu_miso`, `mcu_intn`) from inside the fabric. It takes the role the external BL616/M0S normally plays and is used in board variants without an MCU and in loopback benches. Byte-oriented and full duplex: every byte sent returns one byte from the core. The interrupt line from the core is synchronized and edge-detected.

## Interface
- `CLK_DIV`, default 4: SCLK half-period in `clk32` cycles; legal range 1..255.
- `clk32`  in  1  system clock, 32 MHz.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to transfer `tx_data`; accepted only in IDLE or HOLD.
- `cs_hold`  in  1  sampled with `start`; 1 keeps CSN low after the byte (enters HOLD).
- `release`  in  1  in HOLD: deassert CSN and end the frame.
- `tx_data`  in  8  byte to send, MSB first; sampled with `start`.
- `rx_data`  out  8  last received byte; valid from the `rx_valid` cycle, held until the next `rx_valid`.
- `rx_valid`  out  1  one-cycle pulse when a byte completes.
- `busy`  out  1  high from the cycle after an accepted `start` until IDLE or HOLD is reached.
- `spi_sclk`  out  1  to `mcu_sclk`; idles low.
- `spi_csn`  out  1  to `mcu_csn`, active low.
- `spi_mosi`  out  1  to `mcu_mosi`.
- `spi_miso`  in  1  from `mcu_miso`.
- `spi_intn`  in  1  from `mcu_intn`, active low, asynchronous to `clk32`.
- `irq`  out  1  one-cycle pulse on each falling edge of the synchronized `spi_intn`.
- `irq_level`  out  1  inverted synchronized `spi_intn`.

## Operation
- SPI mode 0: CPOL=0, CPHA=0, MSB first. MOSI is set up while SCLK is low; MISO is sampled on the `clk32` edge that drives SCLK high.
- States and transitions:
  - IDLE: CSN=1, SCLK=0, MOSI=0. `start` → SETUP.
  - SETUP: CSN=0, MOSI=tx[7], SCLK=0 for `CLK_DIV` cycles → HIGH.
  - HIGH: SCLK=1 for `CLK_DIV` cycles; MISO is shifted in on entry → LOW.
  - LOW: SCLK=0 for `CLK_DIV` cycles; on entry, MOSI takes the next bit (MOSI=0 after bit 0).
    - After LOW of bits 7..1 → HIGH.
    - After LOW of bit 0 → DONE.
  - DONE (one cycle): `rx_valid`=1 and `rx_data` updated.
    - If the latched `cs_hold`=1 → HOLD.
    - Otherwise CSN=1 → GAP.
  - HOLD: CSN=0, SCLK=0, `busy`=0.
    - `start` → SETUP; CSN stays low and the SETUP length is unchanged.
    - `release` → GAP.
  - GAP: CSN=1 for `CLK_DIV` cycles → IDLE. Guarantees minimum CSN-high time.
- Shift register and bit counter are internal; the half-period counter is 8 bits.
- `start` outside IDLE/HOLD is ignored and not queued.
- In HOLD, simultaneous `start` and `release`: `release` wins and `start` is ignored.
- `release` outside HOLD is ignored.
- Reset, including mid-transfer: on the next cycle the block is in IDLE.
  - Outputs: CSN=1, SCLK=0, MOSI=0, `busy`=0, `rx_valid`=0, `rx_data`=0x00, `irq`=0, `irq_level`=0.
  - Synchronizer flops preset to 1.

## Timing
- Let `start` be accepted at cycle 0 and D=`CLK_DIV`.
- Cycle 1: CSN falls, `busy` rises, MOSI=tx[7].
- Rising SCLK edge k (k=0..7) occurs at cycle 1+D+2kD; MISO bit 7−k is sampled at that edge.
- Last SCLK falling edge: cycle 1+16D.
- `rx_valid` at cycle 1+17D (D=4 → cycle 69).
- Without hold: CSN rises at cycle 2+17D; IDLE and `busy`=0 at cycle 2+18D.
- With hold: `busy`=0 at cycle 2+17D. Back-to-back: `start` in that cycle restarts the sequence with the same offsets.
- IRQ path (macro defined): 2-flop synchronizer plus edge register. A `spi_intn` fall stable before cycle n gives an `irq` pulse at cycle n+3.

## Configuration
- `MCU_SPI_MASTER_IRQ_EN` defined:
  - `spi_intn` synchronizer and edge detector are present.
  - `irq` and `irq_level` behave as above.
- Not defined:
  - No synchronizer logic; `spi_intn` is unused.
  - `irq` and `irq_level` are tied to 0.
  - The SPI datapath is unchanged.

## Test plan
- D=4, `start` with `tx_data`=0xA5, `cs_hold`=0; slave model returns 0x3C → MOSI bits 1,0,1,0,0,1,0,1 on rising edges 0..7; `rx_valid` at cycle 69 with `rx_data`=0x3C; CSN high at cycle 70; IDLE at cycle 74.
- D=1, `cs_hold`=1, three back-to-back bytes 0x01/0x02/0x03, then `release` → CSN stays low across all three; three `rx_valid` pulses 19 cycles apart; CSN high for exactly 1 cycle of GAP before IDLE.
- `start` pulsed during HIGH of bit 3 with `tx_data`=0xFF → ignored; current byte completes unchanged; no extra transfer follows.
- `reset` asserted at cycle 30 of a D=4 transfer → at cycle 31 CSN=1, SCLK=0, `busy`=0, `rx_data`=0x00; no `rx_valid`; a new `start` afterwards completes normally.
- In HOLD, `start` and `release` in the same cycle → CSN rises next cycle; no SCLK activity.
- Macro defined: `spi_intn` falls asynchronously → exactly one `irq` pulse 3 cycles later; `irq_level`=1 until `spi_intn` rises. Macro undefined: `irq` and `irq_level` stay 0 under the same stimulus.

Source files
------------

// File: rtl/mcu_spi_master.sv
// Byte-oriented SPI mode-0 master for the MCU control link, with optional CSN hold between bytes.
// Optional interrupt synchronizer/edge detector on spi_intn is enabled by defining MCU_SPI_MASTER_IRQ_EN.
module mcu_spi_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk32,
  input  logic       reset,
  input  logic       start,
  input  logic       cs_hold,
  input  logic       release_req,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       spi_sclk,
  output logic       spi_csn,
  output logic       spi_mosi,
  input  logic       spi_miso,
  input  logic       spi_intn,
  output logic       irq,
  output logic       irq_level
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned BIT_W = 3;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_LOW,
    ST_DONE,
    ST_HOLD,
    ST_GAP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [7:0]       tx_sh_q, tx_sh_d;
  logic [7:0]       rx_sh_q, rx_sh_d;
  logic             hold_q, hold_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             busy_q, busy_d;
  logic             sclk_q, sclk_d;
  logic             csn_q, csn_d;
  logic             mosi_q, mosi_d;
  logic             accept;

  always_ff @(posedge clk32) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      hold_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      sclk_q     <= 1'b0;
      csn_q      <= 1'b1;
      mosi_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      hold_q     <= hold_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
      sclk_q     <= sclk_d;
      csn_q      <= csn_d;
      mosi_q     <= mosi_d;
    end
  end

  // Next state and datapath; pins are registered from the next state so they align with state_q.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    hold_d    = hold_q;
    rx_data_d = rx_data_q;
    accept    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) accept = 1'b1;
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_HIGH;
          cnt_d   = CNT_LOAD;
          rx_sh_d = {rx_sh_q[6:0], spi_miso};
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HIGH: begin
        if (cnt_q == '0) begin
          state_d = ST_LOW;
          cnt_d   = CNT_LOAD;
          tx_sh_d = {tx_sh_q[6:0], 1'b0};
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_LOW: begin
        if (cnt_q == '0) begin
          if (bit_q == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_HIGH;
            cnt_d   = CNT_LOAD;
            bit_d   = bit_q - BIT_W'(1);
            rx_sh_d = {rx_sh_q[6:0], spi_miso};
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (hold_q) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_GAP;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_HOLD: begin
        // release has priority over a coincident start
        if (release_req) begin
          state_d = ST_GAP;
          cnt_d   = CNT_LOAD;
        end else if (start) begin
          accept = 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      state_d = ST_SETUP;
      cnt_d   = CNT_LOAD;
      bit_d   = BIT_W'(7);
      tx_sh_d = tx_data;
      hold_d  = cs_hold;
    end

    csn_d      = (state_d == ST_IDLE) || (state_d == ST_GAP);
    sclk_d     = (state_d == ST_HIGH);
    mosi_d     = ((state_d == ST_SETUP) || (state_d == ST_HIGH) || (state_d == ST_LOW))
                 ? tx_sh_d[7] : 1'b0;
    busy_d     = (state_d != ST_IDLE) && (state_d != ST_HOLD);
    rx_valid_d = (state_d == ST_DONE);
    if (state_d == ST_DONE) rx_data_d = rx_sh_d;
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;
  assign spi_sclk = sclk_q;
  assign spi_csn  = csn_q;
  assign spi_mosi = mosi_q;

`ifdef MCU_SPI_MASTER_IRQ_EN
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;
  logic irq_q, irq_d;
  logic irq_level_q, irq_level_d;

  // Two-flop synchronizer, then a delayed copy for falling-edge detection.
  always_ff @(posedge clk32) begin
    if (reset) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      irq_q       <= 1'b0;
      irq_level_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      irq_q       <= irq_d;
      irq_level_q <= irq_level_d;
    end
  end

  always_comb begin
    sync1_d     = spi_intn;
    sync2_d     = sync1_q;
    prev_d      = sync2_q;
    irq_d       = prev_q & ~sync2_q;
    irq_level_d = ~sync2_q;
  end

  assign irq       = irq_q;
  assign irq_level = irq_level_q;
`else
  logic unused_intn;
  assign unused_intn = spi_intn;
  assign irq         = 1'b0;
  assign irq_level   = 1'b0;
`endif

endmodule

// File: tb/tb_mcu_spi_master.sv
// Directed/randomized bench for mcu_spi_master: a D=4 and a D=1 instance, a bus monitor with an
// SPI slave model, and expectations computed from the frame timing formulas.
module tb_mcu_spi_master;

`ifdef MCU_SPI_MASTER_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic clk32 = 1'b0;
  always #5 clk32 = ~clk32;

  logic       reset, start, cs_hold, rel, miso, intn, sel;
  logic [7:0] tx_data;
  logic       start4, start1, rel4, rel1;
  logic [7:0] rxd4, rxd1, m_rxd;
  logic       rxv4, rxv1, busy4, busy1, sclk4, sclk1, csn4, csn1, mosi4, mosi1;
  logic       irq4, irq1, lvl4, lvl1;
  logic       m_rxv, m_busy, m_sclk, m_csn, m_mosi, m_irq, m_lvl;

  assign start4 = start & ~sel;
  assign start1 = start & sel;
  assign rel4   = rel & ~sel;
  assign rel1   = rel & sel;
  assign m_rxd  = sel ? rxd1  : rxd4;
  assign m_rxv  = sel ? rxv1  : rxv4;
  assign m_busy = sel ? busy1 : busy4;
  assign m_sclk = sel ? sclk1 : sclk4;
  assign m_csn  = sel ? csn1  : csn4;
  assign m_mosi = sel ? mosi1 : mosi4;
  assign m_irq  = sel ? irq1  : irq4;
  assign m_lvl  = sel ? lvl1  : lvl4;

  mcu_spi_master #(.CLK_DIV(4)) u_dut4 (
    .clk32(clk32), .reset(reset), .start(start4), .cs_hold(cs_hold), .release_req(rel4),
    .tx_data(tx_data), .rx_data(rxd4), .rx_valid(rxv4), .busy(busy4), .spi_sclk(sclk4),
    .spi_csn(csn4), .spi_mosi(mosi4), .spi_miso(miso), .spi_intn(intn), .irq(irq4),
    .irq_level(lvl4)
  );

  mcu_spi_master #(.CLK_DIV(1)) u_dut1 (
    .clk32(clk32), .reset(reset), .start(start1), .cs_hold(cs_hold), .release_req(rel1),
    .tx_data(tx_data), .rx_data(rxd1), .rx_valid(rxv1), .busy(busy1), .spi_sclk(sclk1),
    .spi_csn(csn1), .spi_mosi(mosi1), .spi_miso(miso), .spi_intn(intn), .irq(irq1),
    .irq_level(lvl1)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int         q_rise[$];
  logic       q_mosi[$];
  int         q_rxv[$];
  logic [7:0] q_rxd[$];
  int         q_cfall[$];
  int         q_crise[$];
  int         q_bfall[$];

  logic [7:0] slv_byte = 8'h00;
  int         nbit = 0;
  logic       p_sclk = 1'b0, p_csn = 1'b1, p_busy = 1'b0;

  // Bus monitor and SPI slave: logs events by cycle, returns slv_byte MSB first.
  always begin
    @(posedge clk32);
    cyc = cyc + 1;
    #2;
    if (m_csn && !p_csn) begin
      q_crise.push_back(cyc);
      nbit = 0;
    end
    if (!m_csn && p_csn) q_cfall.push_back(cyc);
    if (m_sclk && !p_sclk) begin
      q_rise.push_back(cyc);
      q_mosi.push_back(m_mosi);
      nbit = (nbit + 1) % 8;
    end
    if (m_rxv === 1'b1) begin
      q_rxv.push_back(cyc);
      q_rxd.push_back(m_rxd);
    end
    if (!m_busy && p_busy) q_bfall.push_back(cyc);
    miso   = m_csn ? 1'b0 : slv_byte[7-nbit];
    p_sclk = m_sclk;
    p_csn  = m_csn;
    p_busy = m_busy;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk32);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    q_rise.delete();
    q_mosi.delete();
    q_rxv.delete();
    q_rxd.delete();
    q_cfall.delete();
    q_crise.delete();
    q_bfall.delete();
  endtask

  function automatic logic [7:0] mosi_byte(input int b);
    logic [7:0] r;
    r = 'x;
    for (int i = 0; i < 8; i++) r = {r[6:0], q_mosi[8*b+i]};
    return r;
  endfunction

  // Pulse start for one cycle; t0 is the accept cycle. Checks the first-cycle outputs.
  task automatic go(input logic [7:0] tx, input logic hold, input logic [7:0] sb, output int t0);
    slv_byte = sb;
    tx_data  = tx;
    cs_hold  = hold;
    start    = 1'b1;
    t0       = cyc;
    tick(1);
    start    = 1'b0;
    chk("go_csn_low", m_csn, 1'b0);
    chk("go_busy", m_busy, 1'b1);
    chk("go_mosi_msb", m_mosi, tx[7]);
  endtask

  task automatic check_xfer(input string tag, input int t0, input int d,
                            input logic [7:0] tx, input logic [7:0] sb);
    chk({tag, "_csn_falls"}, q_cfall.size(), 1);
    chk({tag, "_csn_fall_cyc"}, q_cfall[0], t0 + 1);
    chk({tag, "_sclk_rises"}, q_rise.size(), 8);
    chk({tag, "_rise0_cyc"}, q_rise[0], t0 + 1 + d);
    chk({tag, "_rise7_cyc"}, q_rise[7], t0 + 1 + 15*d);
    chk({tag, "_mosi_byte"}, mosi_byte(0), tx);
    chk({tag, "_rxv_count"}, q_rxv.size(), 1);
    chk({tag, "_rxv_cyc"}, q_rxv[0], t0 + 1 + 17*d);
    chk({tag, "_rx_data"}, q_rxd[0], sb);
    chk({tag, "_csn_rise_cyc"}, q_crise[0], t0 + 2 + 17*d);
    chk({tag, "_busy_fall_cyc"}, q_bfall[0], t0 + 2 + 18*d);
  endtask

  initial begin
    int         t0, t1, t2, t3, r, c, npulse;
    logic [7:0] tx, sb;
    logic [7:0] hb[3];
    logic [7:0] hs[3];

    reset = 1'b1; start = 1'b0; cs_hold = 1'b0; rel = 1'b0; tx_data = 8'h00;
    intn = 1'b1; sel = 1'b0; miso = 1'b0;
    tick(3);
    chk("rst_csn", m_csn, 1'b1);
    chk("rst_sclk", m_sclk, 1'b0);
    chk("rst_mosi", m_mosi, 1'b0);
    chk("rst_busy", m_busy, 1'b0);
    chk("rst_rxv", m_rxv, 1'b0);
    chk("rst_rxd", m_rxd, 8'h00);
    chk("rst_irq", m_irq, 1'b0);
    chk("rst_irq_level", m_lvl, 1'b0);
    reset = 1'b0;
    tick(2);

    // Directed byte, D=4
    clear_log();
    go(8'hA5, 1'b0, 8'h3C, t0);
    tick(80);
    check_xfer("a5", t0, 4, 8'hA5, 8'h3C);

    // Random bytes, D=4
    for (int i = 0; i < 4; i++) begin
      tx = 8'($urandom);
      sb = 8'($urandom);
      clear_log();
      go(tx, 1'b0, sb, t0);
      tick(80);
      check_xfer("rnd", t0, 4, tx, sb);
    end

    // Start during HIGH of bit 3 is ignored
    tx = 8'($urandom_range(0, 127));
    clear_log();
    go(tx, 1'b0, 8'h96, t0);
    tick(37);
    tx_data = 8'hFF;
    start   = 1'b1;
    tick(1);
    start   = 1'b0;
    tick(60);
    check_xfer("ign", t0, 4, tx, 8'h96);
    tick(20);
    chk("ign_no_extra_frame", q_cfall.size(), 1);
    chk("ign_no_extra_sclk", q_rise.size(), 8);

    // Reset in the middle of a transfer
    clear_log();
    go(8'($urandom), 1'b0, 8'h5A, t0);
    tick(29);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("mid_rst_csn", m_csn, 1'b1);
    chk("mid_rst_sclk", m_sclk, 1'b0);
    chk("mid_rst_busy", m_busy, 1'b0);
    chk("mid_rst_rxd", m_rxd, 8'h00);
    tick(60);
    chk("mid_rst_no_rxv", q_rxv.size(), 0);
    tx = 8'($urandom);
    sb = 8'($urandom);
    clear_log();
    go(tx, 1'b0, sb, t0);
    tick(80);
    check_xfer("post_rst", t0, 4, tx, sb);

    // HOLD with start and release together: release wins
    clear_log();
    go(8'hC3, 1'b1, 8'h81, t0);
    tick(69);
    chk("hsr_hold_busy", m_busy, 1'b0);
    chk("hsr_hold_csn", m_csn, 1'b0);
    start = 1'b1;
    rel   = 1'b1;
    tick(1);
    start = 1'b0;
    rel   = 1'b0;
    chk("hsr_csn_high", m_csn, 1'b1);
    tick(25);
    chk("hsr_no_sclk", q_rise.size(), 8);
    chk("hsr_one_frame", q_cfall.size(), 1);
    chk("hsr_rxd", q_rxd[0], 8'h81);

    // D=1, three held bytes back to back, then release
    tick(2);
    sel = 1'b1;
    tick(2);
    clear_log();
    hb[0] = 8'h01; hb[1] = 8'h02; hb[2] = 8'h03;
    for (int i = 0; i < 3; i++) hs[i] = 8'($urandom);
    go(hb[0], 1'b1, hs[0], t0);
    tick(18);
    chk("b2b_hold0_busy", m_busy, 1'b0);
    go(hb[1], 1'b1, hs[1], t1);
    tick(18);
    go(hb[2], 1'b1, hs[2], t2);
    tick(18);
    chk("b2b_hold2_busy", m_busy, 1'b0);
    chk("b2b_hold2_csn", m_csn, 1'b0);
    rel = 1'b1;
    r   = cyc;
    tick(1);
    rel = 1'b0;
    chk("b2b_gap_csn", m_csn, 1'b1);
    tx_data = 8'hEE;
    start   = 1'b1;
    tick(1);
    start   = 1'b0;
    chk("b2b_gap_start_ignored", m_csn, 1'b1);
    go(8'h7E, 1'b0, 8'h42, t3);
    tick(25);
    chk("b2b_rxv_count", q_rxv.size(), 4);
    for (int i = 0; i < 3; i++) begin
      chk("b2b_rxv_cyc", q_rxv[i], t0 + 18 + 19*i);
      chk("b2b_rxd", q_rxd[i], hs[i]);
      chk("b2b_mosi", mosi_byte(i), hb[i]);
    end
    chk("b2b_csn_falls", q_cfall.size(), 2);
    chk("b2b_csn_fall0", q_cfall[0], t0 + 1);
    chk("b2b_csn_fall1", q_cfall[1], r + 3);
    chk("b2b_csn_rise0", q_crise[0], r + 1);
    chk("b2b_sclk_rises", q_rise.size(), 32);
    chk("b2b_last_rxd", q_rxd[3], 8'h42);

    // Interrupt line: asynchronous fall, later rise
    tick(2);
    #($urandom_range(1, 3));
    intn   = 1'b0;
    c      = cyc;
    npulse = 0;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      if (m_irq === 1'b1) npulse++;
      if (k == 2) chk("irq_early", m_irq, 1'b0);
      if (k == 3) chk("irq_pulse", m_irq, IRQ_ON);
      if (k == 4) chk("irq_one_cycle", m_irq, 1'b0);
      if (k == 5) begin
        chk("irq_level_low_intn", m_lvl, IRQ_ON);
        intn = 1'b1;
      end
      if (k == 12) chk("irq_level_released", m_lvl, 1'b0);
    end
    chk("irq_pulse_count", npulse, {31'd0, IRQ_ON});
    chk("irq_cycle_base", cyc, c + 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
